// File: rtl/pipeline_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer.
// SKID=1: head + skid entries, In_Ready registered (breaks the ready path).
// SKID=0: single head register, In_Ready combinational from Out_Ready.
module pipeline_stage_reg #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 160,
    parameter int SKID   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              Flush,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HEAD  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CTRL_W-1:0] head_ctrl, head_ctrl_nxt;
    logic [DATA_W-1:0] head_data, head_data_nxt;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
    logic [DATA_W-1:0] skid_data, skid_data_nxt;
    logic              valid_q, valid_nxt;
    logic              ready_q, ready_nxt;
    logic              ready;
    logic              push;
    logic              pop;

    // With a skid entry the ready is a flop; without one it is the usual
    // "space now or space after this pop" combinational term.
    assign ready = (SKID != 0) ? ready_q : (!valid_q | Out_Ready);
    assign push  = In_Valid & ready;
    assign pop   = valid_q & Out_Ready;

    assign In_Ready  = ready;
    assign Out_Valid = valid_q;
    assign Out_Ctrl  = head_ctrl;
    assign Out_Data  = head_data;
    assign Occupancy = state;

    // Next-state and next-contents; flush overrides every transfer.
    always_comb begin
        state_nxt     = state;
        head_ctrl_nxt = head_ctrl;
        head_data_nxt = head_data;
        skid_ctrl_nxt = skid_ctrl;
        skid_data_nxt = skid_data;

        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt     = HEAD;
                    head_ctrl_nxt = In_Ctrl;
                    head_data_nxt = In_Data;
                end
            end
            HEAD: begin
                if (push && pop) begin
                    head_ctrl_nxt = In_Ctrl;
                    head_data_nxt = In_Data;
                end else if (push) begin
                    // Only reachable with SKID=1: without a skid, push in
                    // HEAD requires a simultaneous pop.
                    state_nxt     = FULL;
                    skid_ctrl_nxt = In_Ctrl;
                    skid_data_nxt = In_Data;
                end else if (pop) begin
                    // Bubble: control cleared, data left as-is.
                    state_nxt     = EMPTY;
                    head_ctrl_nxt = '0;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt     = HEAD;
                    head_ctrl_nxt = skid_ctrl;
                    head_data_nxt = skid_data;
                    skid_ctrl_nxt = '0;
                end
            end
            default: begin
                state_nxt     = EMPTY;
                head_ctrl_nxt = '0;
                skid_ctrl_nxt = '0;
            end
        endcase

        if (Flush) begin
            state_nxt     = EMPTY;
            head_ctrl_nxt = '0;
            head_data_nxt = head_data;
            skid_ctrl_nxt = '0;
            skid_data_nxt = skid_data;
        end

        valid_nxt = (state_nxt != EMPTY);
        ready_nxt = (state_nxt != FULL);
    end

    // State and bundle registers; reset clears everything immediately.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= EMPTY;
            head_ctrl <= '0;
            head_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state     <= state_nxt;
            head_ctrl <= head_ctrl_nxt;
            head_data <= head_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
            skid_data <= skid_data_nxt;
            valid_q   <= valid_nxt;
            ready_q   <= ready_nxt;
        end
    end

    // A push while FULL cannot happen; neither can FULL without a skid.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            assert (!(state == FULL && push));
            assert (SKID != 0 || state != FULL);
        end
    end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench: drives one SKID=1 and one SKID=0 instance with identical stimulus
// and compares both against a small FIFO model of the stage.
module tb_pipeline_stage_reg;
    localparam int CW = 9;
    localparam int DW = 160;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          In_Valid;
    logic          Flush;
    logic          Out_Ready;
    logic [CW-1:0] In_Ctrl;
    logic [DW-1:0] In_Data;

    logic          rdy [2];
    logic          ov  [2];
    logic [CW-1:0] oc  [2];
    logic [DW-1:0] od  [2];
    logic [1:0]    occ [2];

    int total = 0;
    int bad   = 0;

    // Model: up to two entries per instance, index 0 is the head.
    ent_t          mq   [2][2];
    int            mcnt [2];
    logic [DW-1:0] last [2];

    always #5 Clk = ~Clk;

    pipeline_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_skid (
        .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(rdy[0]),
        .In_Ctrl(In_Ctrl), .In_Data(In_Data), .Flush(Flush),
        .Out_Valid(ov[0]), .Out_Ready(Out_Ready), .Out_Ctrl(oc[0]),
        .Out_Data(od[0]), .Occupancy(occ[0])
    );

    pipeline_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_flat (
        .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(rdy[1]),
        .In_Ctrl(In_Ctrl), .In_Data(In_Data), .Flush(Flush),
        .Out_Valid(ov[1]), .Out_Ready(Out_Ready), .Out_Ctrl(oc[1]),
        .Out_Data(od[1]), .Occupancy(occ[1])
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready(input int k);
        if (k == 0) return mcnt[0] < 2;
        return (mcnt[1] == 0) || Out_Ready;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            last[k] = '0;
        end
    endtask

    // Applies the edge just taken using the inputs that were stable across it.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic r, p, u;
            r = model_ready(k);
            p = (mcnt[k] > 0) && Out_Ready;
            u = In_Valid && r;
            if (Flush) begin
                mcnt[k] = 0;
            end else begin
                if (p) begin
                    mq[k][0] = mq[k][1];
                    mcnt[k]--;
                end
                if (u) begin
                    mq[k][mcnt[k]] = '{c: In_Ctrl, d: In_Data};
                    mcnt[k]++;
                end
            end
            if (mcnt[k] > 0) last[k] = mq[k][0].d;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("in_ready[%0d]", k), 256'(rdy[k]), 256'(model_ready(k)));
            check($sformatf("out_valid[%0d]", k), 256'(ov[k]), 256'(mcnt[k] > 0));
            check($sformatf("out_ctrl[%0d]", k), 256'(oc[k]),
                  (mcnt[k] > 0) ? 256'(mq[k][0].c) : 256'(0));
            check($sformatf("out_data[%0d]", k), 256'(od[k]),
                  (mcnt[k] > 0) ? 256'(mq[k][0].d) : 256'(last[k]));
            check($sformatf("occupancy[%0d]", k), 256'(occ[k]), 256'(mcnt[k]));
        end
    endtask

    // Check before the edge, take the edge, update the model, settle.
    task automatic cycle();
        @(negedge Clk);
        check_all();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        In_Valid = v;
        In_Ctrl  = c;
        In_Data  = d;
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, '0, '0);
        Flush     = 1'b0;
        Out_Ready = 1'b0;
        model_reset();
        #2;
        check_all();
        check("reset_ready_skid", 256'(rdy[0]), 256'(1));
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        // Streaming at full rate.
        Out_Ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 9'h1A5, DW'(i));
            cycle();
        end
        check("stream_occ", 256'(occ[0]), 256'(1));
        check("stream_data", 256'(od[0]), 256'(4));
        drive(1'b0, '0, '0);
        cycle();
        cycle();

        // Backpressure: fill the skid, then drain.
        Out_Ready = 1'b0;
        drive(1'b1, 9'h011, DW'('hA));
        cycle();
        drive(1'b1, 9'h022, DW'('hB));
        cycle();
        drive(1'b0, '0, '0);
        #1;
        check("bp_occ_full", 256'(occ[0]), 256'(2));
        check("bp_ready_low", 256'(rdy[0]), 256'(0));
        check("bp_head_a", 256'(od[0]), 256'('hA));
        cycle();
        Out_Ready = 1'b1;
        cycle();
        check("bp_head_b", 256'(od[0]), 256'('hB));
        check("bp_ready_back", 256'(rdy[0]), 256'(1));
        cycle();
        check("bp_empty", 256'(occ[0]), 256'(0));
        cycle();

        // Flush beats a simultaneous push and pop.
        Out_Ready = 1'b0;
        drive(1'b1, 9'h033, DW'('hC));
        cycle();
        drive(1'b1, 9'h044, DW'('hD));
        cycle();
        Flush     = 1'b1;
        Out_Ready = 1'b1;
        drive(1'b1, 9'h077, DW'('h77));
        cycle();
        Flush = 1'b0;
        drive(1'b0, '0, '0);
        #1;
        check("flush_valid", 256'(ov[0]), 256'(0));
        check("flush_ctrl", 256'(oc[0]), 256'(0));
        check("flush_occ", 256'(occ[0]), 256'(0));
        cycle();
        cycle();

        // Asynchronous reset between edges while FULL.
        Out_Ready = 1'b0;
        drive(1'b1, 9'h055, DW'('h5));
        cycle();
        drive(1'b1, 9'h066, DW'('h6));
        cycle();
        drive(1'b0, '0, '0);
        @(negedge Clk);
        #1 Reset = 1'b1;
        #1;
        check("areset_valid", 256'(ov[0]), 256'(0));
        check("areset_ctrl", 256'(oc[0]), 256'(0));
        check("areset_data", 256'(od[0]), 256'(0));
        check("areset_occ", 256'(occ[0]), 256'(0));
        model_reset();
        check_all();
        @(posedge Clk);
        #1 Reset = 1'b0;
        drive(1'b1, 9'h0F0, DW'('h99));
        cycle();
        drive(1'b0, '0, '0);
        cycle();

        // SKID=0 ready follows Out_Ready combinationally.
        Out_Ready = 1'b0;
        #1;
        check("flat_ready_low", 256'(rdy[1]), 256'(0));
        cycle();
        Out_Ready = 1'b1;
        drive(1'b1, 9'h1FF, DW'('hEE));
        #1;
        check("flat_ready_high", 256'(rdy[1]), 256'(1));
        cycle();
        check("flat_replaced", 256'(od[1]), 256'('hEE));
        check("flat_occ", 256'(occ[1]), 256'(1));

        // Random traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            Out_Ready = 1'($urandom_range(0, 3) != 0);
            Flush     = 1'($urandom_range(0, 15) == 0);
            drive(1'($urandom_range(0, 1)), CW'($urandom),
                  {$urandom, $urandom, $urandom, $urandom, $urandom});
            cycle();
        end
        Flush = 1'b0;
        drive(1'b0, '0, '0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
